// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath width, operation encodings and legality check.
package alu_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [3:0] {
    ALU_ADD = 4'b0000,
    ALU_SUB = 4'b0001,
    ALU_AND = 4'b0010,
    ALU_OR  = 4'b0011,
    ALU_NOT = 4'b0100,
    ALU_SLT = 4'b1000
  } alu_op_e;

  function automatic logic is_legal_op(input logic [3:0] op);
    case (op)
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_NOT, ALU_SLT: return 1'b1;
      default:                                            return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/fwd_mux.sv
// Operand forwarding select: EX/MEM over MEM/WB over register file; x0 never forwarded.
module fwd_mux #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic [REG_AW-1:0] Rs,
  input  logic [XLEN-1:0]   RsData,
  input  logic              ExMemRegWrite,
  input  logic [REG_AW-1:0] ExMemRd,
  input  logic [XLEN-1:0]   ExMemResult,
  input  logic              MemWbRegWrite,
  input  logic [REG_AW-1:0] MemWbRd,
  input  logic [XLEN-1:0]   MemWbResult,
  output logic [XLEN-1:0]   Fwd
);

  always_comb begin
    Fwd = RsData;
    if (ExMemRegWrite && (ExMemRd != '0) && (ExMemRd == Rs))
      Fwd = ExMemResult;
    else if (MemWbRegWrite && (MemWbRd != '0) && (MemWbRd == Rs))
      Fwd = MemWbResult;
  end

endmodule

// File: rtl/id_ex_stage.sv
// Decode->execute pipeline register: forwarding, immediate select, op legality,
// valid/ready handshake with flush, and a saturating stall counter.
module id_ex_stage
  import alu_pkg::*;
#(
  parameter int unsigned XLEN    = alu_pkg::XLEN,
  parameter int unsigned IMM_W   = 12,
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned STALL_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               Flush,
  input  logic               InValid,
  output logic               InReady,
  input  logic [REG_AW-1:0]  Rs1,
  input  logic [REG_AW-1:0]  Rs2,
  input  logic [XLEN-1:0]    Rs1Data,
  input  logic [XLEN-1:0]    Rs2Data,
  input  logic [IMM_W-1:0]   Imm,
  input  logic               UseImm,
  input  logic [3:0]         AluOp,
  input  logic [REG_AW-1:0]  Rd,
  input  logic               RegWrite,
  input  logic               ExMemRegWrite,
  input  logic [REG_AW-1:0]  ExMemRd,
  input  logic [XLEN-1:0]    ExMemResult,
  input  logic               MemWbRegWrite,
  input  logic [REG_AW-1:0]  MemWbRd,
  input  logic [XLEN-1:0]    MemWbResult,
  output logic               OutValid,
  input  logic               OutReady,
  output logic [XLEN-1:0]    A,
  output logic [XLEN-1:0]    B,
  output logic [3:0]         ALUControl,
  output logic [REG_AW-1:0]  OutRd,
  output logic               OutRegWrite,
  output logic               IllegalOp,
  output logic [STALL_W-1:0] StallCount
);

  logic [XLEN-1:0] fwd_a;
  logic [XLEN-1:0] fwd_b;
  logic [XLEN-1:0] imm_sext;
  logic            load;
  logic            stall;
  logic            op_legal;

  fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_a (
    .Rs(Rs1), .RsData(Rs1Data),
    .ExMemRegWrite(ExMemRegWrite), .ExMemRd(ExMemRd), .ExMemResult(ExMemResult),
    .MemWbRegWrite(MemWbRegWrite), .MemWbRd(MemWbRd), .MemWbResult(MemWbResult),
    .Fwd(fwd_a)
  );

  fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_b (
    .Rs(Rs2), .RsData(Rs2Data),
    .ExMemRegWrite(ExMemRegWrite), .ExMemRd(ExMemRd), .ExMemResult(ExMemResult),
    .MemWbRegWrite(MemWbRegWrite), .MemWbRd(MemWbRd), .MemWbResult(MemWbResult),
    .Fwd(fwd_b)
  );

  always_comb begin
    InReady  = !OutValid || OutReady;
    load     = InValid && InReady;
    stall    = OutValid && !OutReady;
    op_legal = is_legal_op(AluOp);
    imm_sext = {{(XLEN-IMM_W){Imm[IMM_W-1]}}, Imm};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      OutValid    <= 1'b0;
      A           <= '0;
      B           <= '0;
      ALUControl  <= ALU_ADD;
      OutRd       <= '0;
      OutRegWrite <= 1'b0;
      IllegalOp   <= 1'b0;
      StallCount  <= '0;
    end else begin
      // Counted independently of flush/load so a flushed stall cycle still counts.
      if (stall && (StallCount != '1))
        StallCount <= StallCount + 1'b1;

      if (Flush) begin
        OutValid    <= 1'b0;
        OutRegWrite <= 1'b0;
      end else if (load) begin
        OutValid    <= 1'b1;
        A           <= fwd_a;
        B           <= UseImm ? imm_sext : fwd_b;
        ALUControl  <= op_legal ? AluOp : ALU_ADD;
        OutRd       <= Rd;
        OutRegWrite <= RegWrite && op_legal;
        IllegalOp   <= !op_legal;
      end else if (OutValid && OutReady) begin
        OutValid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage using immediate assertions.
module tb_id_ex_stage;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned IMM_W   = 12;
  localparam int unsigned REG_AW  = 5;
  localparam int unsigned STALL_W = 4;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               Flush;
  logic               InValid;
  logic               InReady;
  logic [REG_AW-1:0]  Rs1, Rs2, Rd, ExMemRd, MemWbRd, OutRd;
  logic [XLEN-1:0]    Rs1Data, Rs2Data, ExMemResult, MemWbResult, A, B;
  logic [IMM_W-1:0]   Imm;
  logic               UseImm, RegWrite, ExMemRegWrite, MemWbRegWrite;
  logic [3:0]         AluOp, ALUControl;
  logic               OutValid, OutReady, OutRegWrite, IllegalOp;
  logic [STALL_W-1:0] StallCount;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(XLEN), .IMM_W(IMM_W), .REG_AW(REG_AW), .STALL_W(STALL_W)) dut (
    .clk(clk), .rst_n(rst_n), .Flush(Flush), .InValid(InValid), .InReady(InReady),
    .Rs1(Rs1), .Rs2(Rs2), .Rs1Data(Rs1Data), .Rs2Data(Rs2Data), .Imm(Imm),
    .UseImm(UseImm), .AluOp(AluOp), .Rd(Rd), .RegWrite(RegWrite),
    .ExMemRegWrite(ExMemRegWrite), .ExMemRd(ExMemRd), .ExMemResult(ExMemResult),
    .MemWbRegWrite(MemWbRegWrite), .MemWbRd(MemWbRd), .MemWbResult(MemWbResult),
    .OutValid(OutValid), .OutReady(OutReady), .A(A), .B(B), .ALUControl(ALUControl),
    .OutRd(OutRd), .OutRegWrite(OutRegWrite), .IllegalOp(IllegalOp), .StallCount(StallCount)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_outvalid"},   32'(OutValid),    32'd0);
    chk({tag, "_a"},          A,                32'd0);
    chk({tag, "_b"},          B,                32'd0);
    chk({tag, "_aluctl"},     32'(ALUControl),  32'd0);
    chk({tag, "_outrd"},      32'(OutRd),       32'd0);
    chk({tag, "_outregwr"},   32'(OutRegWrite), 32'd0);
    chk({tag, "_illegal"},    32'(IllegalOp),   32'd0);
    chk({tag, "_stallcount"}, 32'(StallCount),  32'd0);
  endtask

  initial begin
    rst_n = 1'b0; Flush = 1'b0; InValid = 1'b0; OutReady = 1'b1;
    Rs1 = '0; Rs2 = '0; Rd = '0; Rs1Data = '0; Rs2Data = '0;
    Imm = '0; UseImm = 1'b0; AluOp = 4'b0000; RegWrite = 1'b0;
    ExMemRegWrite = 1'b0; ExMemRd = '0; ExMemResult = '0;
    MemWbRegWrite = 1'b0; MemWbRd = '0; MemWbResult = '0;

    // Reset state
    step(); step();
    chk_zero_outputs("reset");
    chk("reset_inready", 32'(InReady), 32'd1);
    rst_n = 1'b1;

    // Forwarding priority
    InValid = 1'b1; Rs1 = 5; Rs1Data = 32'h1; AluOp = 4'b0000; Rd = 7; RegWrite = 1'b1;
    ExMemRegWrite = 1'b1; ExMemRd = 5; ExMemResult = 32'h22;
    MemWbRegWrite = 1'b1; MemWbRd = 5; MemWbResult = 32'h33;
    Rs2 = 5; Rs2Data = 32'h44;
    step();
    chk("fwd_exmem_valid", 32'(OutValid), 32'd1);
    chk("fwd_exmem_a", A, 32'h22);
    chk("fwd_exmem_b", B, 32'h22);
    chk("fwd_outrd", 32'(OutRd), 32'd7);
    chk("fwd_outregwr", 32'(OutRegWrite), 32'd1);
    ExMemRegWrite = 1'b0;
    step();
    chk("fwd_memwb_a", A, 32'h33);
    chk("fwd_memwb_b", B, 32'h33);
    Rs1 = 0; Rs1Data = 32'h1234; ExMemRegWrite = 1'b1; ExMemRd = 0; MemWbRd = 0;
    Rs2 = 3; Rs2Data = 32'h55;
    step();
    chk("fwd_x0_a", A, 32'h1234);
    chk("fwd_nomatch_b", B, 32'h55);

    // Immediate sign extension
    ExMemRegWrite = 1'b0; MemWbRegWrite = 1'b0;
    UseImm = 1'b1; Imm = 12'hFFF;
    step();
    chk("imm_neg_b", B, 32'hFFFF_FFFF);
    Imm = 12'h7FF;
    step();
    chk("imm_pos_b", B, 32'h0000_07FF);
    UseImm = 1'b0;

    // Illegal op and recovery
    AluOp = 4'b0111; RegWrite = 1'b1;
    step();
    chk("illegal_aluctl", 32'(ALUControl), 32'd0);
    chk("illegal_flag", 32'(IllegalOp), 32'd1);
    chk("illegal_regwr", 32'(OutRegWrite), 32'd0);
    AluOp = 4'b1000;
    step();
    chk("legal_aluctl", 32'(ALUControl), 32'h8);
    chk("legal_flag", 32'(IllegalOp), 32'd0);
    chk("legal_regwr", 32'(OutRegWrite), 32'd1);
    chk("pre_bp_stallcount", 32'(StallCount), 32'd0);

    // Backpressure: four ops, two stall cycles on the first
    Rs1 = 9; Rs1Data = 32'h101; AluOp = 4'b0001;
    step();
    chk("bp_op1_a", A, 32'h101);
    OutReady = 1'b0; Rs1Data = 32'h102; AluOp = 4'b0010;
    #1;
    chk("bp_inready_low", 32'(InReady), 32'd0);
    step();
    chk("bp_stall1_a", A, 32'h101);
    chk("bp_stall1_ctl", 32'(ALUControl), 32'h1);
    step();
    chk("bp_stall2_a", A, 32'h101);
    chk("bp_stall2_ctl", 32'(ALUControl), 32'h1);
    chk("bp_stallcount", 32'(StallCount), 32'd2);
    OutReady = 1'b1;
    step();
    chk("bp_op2_a", A, 32'h102);
    chk("bp_op2_ctl", 32'(ALUControl), 32'h2);
    Rs1Data = 32'h103; AluOp = 4'b0011;
    step();
    chk("bp_op3_a", A, 32'h103);
    Rs1Data = 32'h104; AluOp = 4'b0100;
    step();
    chk("bp_op4_a", A, 32'h104);
    chk("bp_op4_ctl", 32'(ALUControl), 32'h4);
    InValid = 1'b0;
    step();
    chk("bp_drain_valid", 32'(OutValid), 32'd0);
    chk("bp_drain_a_hold", A, 32'h104);
    chk("bp_final_stallcount", 32'(StallCount), 32'd2);

    // Flush vs load on the same edge
    InValid = 1'b1; RegWrite = 1'b1; AluOp = 4'b0000; Rs1Data = 32'h200;
    step();
    chk("flush_pre_valid", 32'(OutValid), 32'd1);
    Flush = 1'b1; Rs1Data = 32'h201;
    step();
    chk("flush_valid", 32'(OutValid), 32'd0);
    chk("flush_regwr", 32'(OutRegWrite), 32'd0);
    chk("flush_a_hold", A, 32'h200);
    Flush = 1'b0;

    // Flush while stalled still counts that cycle
    step();
    OutReady = 1'b0; Flush = 1'b1; InValid = 1'b0;
    step();
    chk("flush_stall_valid", 32'(OutValid), 32'd0);
    chk("flush_stall_count", 32'(StallCount), 32'd3);
    Flush = 1'b0; OutReady = 1'b1;

    // Saturation at all-ones
    InValid = 1'b1;
    step();
    InValid = 1'b0; OutReady = 1'b0;
    for (int i = 0; i < 20; i++) step();
    chk("sat_stallcount", 32'(StallCount), 32'd15);
    chk("sat_valid_hold", 32'(OutValid), 32'd1);

    // Asynchronous reset mid-stall
    #2 rst_n = 1'b0;
    #1;
    chk_zero_outputs("async_reset");
    #3 rst_n = 1'b1;
    OutReady = 1'b1; InValid = 1'b1; Rs1Data = 32'h300;
    step();
    chk("post_reset_valid", 32'(OutValid), 32'd1);
    chk("post_reset_a", A, 32'h300);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
